// File: rtl/input_router_if.sv
// Bundles the input_router's SPAD read port, start request and PE-side handshake.
// The router side uses modport master and the environment side uses modport slave.
interface input_router_if #(
    parameter int SPAD_ADDR_WIDTH = 8,
    parameter int SPAD_DATA_WIDTH = 16,
    parameter int ROUTER_COUNT    = 4,
    parameter int DATA_WIDTH      = 8
);
    logic                                  i_en;
    logic [SPAD_ADDR_WIDTH-1:0]            i_base_addr;
    logic [ROUTER_COUNT-1:0]               i_pe_mask;
    logic                                  o_spad_rd_en;
    logic [SPAD_ADDR_WIDTH-1:0]            o_spad_addr;
    logic [SPAD_DATA_WIDTH-1:0]            i_spad_data;
    logic [0:ROUTER_COUNT-1][DATA_WIDTH-1:0] o_ifmap;
    logic [ROUTER_COUNT-1:0]               o_valid;
    logic                                  i_ready;
    logic                                  o_busy;
    logic                                  o_done;

    modport master (
        input  i_en, i_base_addr, i_pe_mask, i_spad_data, i_ready,
        output o_spad_rd_en, o_spad_addr, o_ifmap, o_valid, o_busy, o_done
    );

    modport slave (
        output i_en, i_base_addr, i_pe_mask, i_spad_data, i_ready,
        input  o_spad_rd_en, o_spad_addr, o_ifmap, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/input_router.sv
// Fetches GROUP_CNT consecutive SPAD words, unpacks them into one lane per PE
// (lane 0 in the word MSBs) and offers them to the array with a valid/ready handshake.
module input_router #(
    parameter int SPAD_ADDR_WIDTH = 8,
    parameter int SPAD_DATA_WIDTH = 16,
    parameter int ROUTER_COUNT    = 4,
    parameter int DATA_WIDTH      = 8
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input_router_if.master bus
);
    localparam int MEMBER_CNT = (SPAD_DATA_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int GROUP_CNT  = (ROUTER_COUNT + MEMBER_CNT - 1) / MEMBER_CNT;
    localparam int CNT_W      = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;
    localparam int PAD_W      = MEMBER_CNT * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP_CNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                                  state_r;
    state_t                                  next_state_s;
    logic [CNT_W-1:0]                        rd_cnt_r;
    logic [CNT_W-1:0]                        cap_idx_r;
    logic                                    cap_en_r;
    logic                                    done_r;
    logic [SPAD_ADDR_WIDTH-1:0]              base_r;
    logic [ROUTER_COUNT-1:0]                 mask_r;
    logic [SPAD_DATA_WIDTH-1:0]              shadow_r     [GROUP_CNT];
    logic [PAD_W-1:0]                        shadow_pad_s [GROUP_CNT];
    logic [DATA_WIDTH-1:0]                   lane_s       [ROUTER_COUNT];
    logic [0:ROUTER_COUNT-1][DATA_WIDTH-1:0] ifmap_s;
    logic [ROUTER_COUNT-1:0]                 valid_s;
    logic                                    last_rd_s;

    assign last_rd_s = (rd_cnt_r == LAST_CNT);

    // Next-state decode for the IDLE -> READ -> DRAIN -> OUT sequence
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_en) next_state_s = ST_READ;
                else          next_state_s = ST_IDLE;
            end
            ST_READ: begin
                if (last_rd_s) next_state_s = ST_DRAIN;
                else           next_state_s = ST_READ;
            end
            ST_DRAIN: next_state_s = ST_OUT;
            ST_OUT: begin
                if (bus.i_ready) next_state_s = ST_IDLE;
                else             next_state_s = ST_OUT;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state_r <= ST_IDLE;
        else         state_r <= next_state_s;
    end

    // Request capture, read counter and the one-cycle-delayed capture pointer
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rd_cnt_r  <= '0;
            cap_idx_r <= '0;
            cap_en_r  <= 1'b0;
            done_r    <= 1'b0;
            base_r    <= '0;
            mask_r    <= '0;
        end else begin
            cap_en_r  <= (state_r == ST_READ);
            cap_idx_r <= rd_cnt_r;
            done_r    <= (state_r == ST_OUT) && bus.i_ready;
            case (state_r)
                ST_IDLE: begin
                    rd_cnt_r <= '0;
                    if (bus.i_en) begin
                        base_r <= bus.i_base_addr;
                        mask_r <= bus.i_pe_mask;
                    end else begin
                        base_r <= base_r;
                        mask_r <= mask_r;
                    end
                end
                ST_READ: begin
                    if (last_rd_s) rd_cnt_r <= '0;
                    else           rd_cnt_r <= rd_cnt_r + CNT_W'(1);
                end
                default: rd_cnt_r <= rd_cnt_r;
            endcase
        end
    end

    // Shadow words: read data lands the cycle after its read strobe
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int g = 0; g < GROUP_CNT; g++) shadow_r[g] <= '0;
        end else if (cap_en_r) begin
            shadow_r[cap_idx_r] <= bus.i_spad_data;
        end
    end

    // Zero-extend each word so a non-integral lane count still slices in range
    for (genvar g = 0; g < GROUP_CNT; g++) begin : g_pad
        assign shadow_pad_s[g] = PAD_W'(shadow_r[g]);
    end

    for (genvar k = 0; k < ROUTER_COUNT; k++) begin : g_lane
        localparam int WORD = k / MEMBER_CNT;
        localparam int LANE = k % MEMBER_CNT;
        assign lane_s[k] = shadow_pad_s[WORD][(MEMBER_CNT-1-LANE)*DATA_WIDTH +: DATA_WIDTH];
    end

    // PE-side outputs: only live in OUT, masked lanes forced to zero
    always_comb begin
        ifmap_s = '0;
        valid_s = '0;
        if (state_r == ST_OUT) begin
            valid_s = mask_r;
            for (int k = 0; k < ROUTER_COUNT; k++) begin
                if (mask_r[k]) ifmap_s[k] = lane_s[k];
                else           ifmap_s[k] = '0;
            end
        end else begin
            valid_s = '0;
            ifmap_s = '0;
        end
    end

    assign bus.o_spad_rd_en = (state_r == ST_READ);
    assign bus.o_spad_addr  = (state_r == ST_READ) ? (base_r + SPAD_ADDR_WIDTH'(rd_cnt_r)) : '0;
    assign bus.o_ifmap      = ifmap_s;
    assign bus.o_valid      = valid_s;
    assign bus.o_busy       = (state_r != ST_IDLE);
    assign bus.o_done       = done_r;
endmodule

// File: tb/tb_input_router.sv
// Randomized and directed bench for input_router against a lane-extraction model
// built from the SPAD contents, base address and PE mask.
module tb_input_router;
    localparam int RC  = 4;
    localparam int DW  = 8;
    localparam int MEM = 2;
    localparam int GRP = 2;

    typedef logic [0:RC-1][DW-1:0] ifmap_t;

    logic i_clk  = 1'b0;
    logic i_nrst = 1'b1;
    always #5 i_clk = ~i_clk;

    input_router_if #(.ROUTER_COUNT(4)) bus  ();
    input_router_if #(.ROUTER_COUNT(3)) bus3 ();

    input_router #(.SPAD_ADDR_WIDTH(8), .SPAD_DATA_WIDTH(16), .ROUTER_COUNT(4), .DATA_WIDTH(8))
        dut (.i_clk(i_clk), .i_nrst(i_nrst), .bus(bus));
    input_router #(.SPAD_ADDR_WIDTH(8), .SPAD_DATA_WIDTH(16), .ROUTER_COUNT(3), .DATA_WIDTH(8))
        dut3 (.i_clk(i_clk), .i_nrst(i_nrst), .bus(bus3));

    logic [15:0] spad_mem [256];
    logic [7:0]  rd_log   [$];
    logic [7:0]  rd_log3  [$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPAD read ports: one-cycle latency, junk on the bus when not reading
    always @(posedge i_clk) begin
        if (bus.o_spad_rd_en) begin
            bus.i_spad_data <= spad_mem[bus.o_spad_addr];
            rd_log.push_back(bus.o_spad_addr);
        end else begin
            bus.i_spad_data <= 16'($urandom);
        end
    end

    always @(posedge i_clk) begin
        if (bus3.o_spad_rd_en) begin
            bus3.i_spad_data <= spad_mem[bus3.o_spad_addr];
            rd_log3.push_back(bus3.o_spad_addr);
        end else begin
            bus3.i_spad_data <= 16'($urandom);
        end
    end

    function automatic ifmap_t model_ifmap(input logic [7:0] base, input logic [RC-1:0] mask);
        ifmap_t res;
        for (int k = 0; k < RC; k++) begin
            logic [7:0]  a;
            logic [15:0] w;
            a = base + 8'(k / MEM);
            w = spad_mem[a];
            res[k] = mask[k] ? 8'(w >> ((MEM - 1 - (k % MEM)) * DW)) : 8'h00;
        end
        return res;
    endfunction

    // Starts at a negedge; returns at the negedge where o_done is observed
    task automatic run_xfer(input logic [7:0] base, input logic [3:0] mask, input int d, input string tag);
        ifmap_t exp;
        exp = model_ifmap(base, mask);
        rd_log.delete();
        bus.i_en        = 1'b1;
        bus.i_base_addr = base;
        bus.i_pe_mask   = mask;
        bus.i_ready     = (d == 0);
        @(posedge i_clk); @(negedge i_clk);
        bus.i_en        = 1'b0;
        bus.i_base_addr = 8'($urandom);
        bus.i_pe_mask   = 4'($urandom);
        check_value($sformatf("%s.c1_busy_done_valid", tag), {bus.o_busy, bus.o_done, bus.o_valid}, {1'b1, 1'b0, 4'h0});
        for (int c = 2; c <= GRP + 1; c++) begin
            @(posedge i_clk); @(negedge i_clk);
            check_value($sformatf("%s.c%0d_valid", tag, c), bus.o_valid, 4'h0);
        end
        @(posedge i_clk); @(negedge i_clk);
        check_value($sformatf("%s.valid", tag), bus.o_valid, mask);
        check_value($sformatf("%s.ifmap", tag), bus.o_ifmap, exp);
        check_value($sformatf("%s.out_done", tag), bus.o_done, 1'b0);
        for (int i = 0; i < d; i++) begin
            if (i == 1) bus.i_en = 1'b1;
            @(posedge i_clk); @(negedge i_clk);
            bus.i_en = 1'b0;
            check_value($sformatf("%s.hold%0d", tag, i), {bus.o_valid, bus.o_ifmap, bus.o_done}, {mask, exp, 1'b0});
        end
        bus.i_ready = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        bus.i_ready = 1'b0;
        check_value($sformatf("%s.done", tag), {bus.o_done, bus.o_busy, bus.o_valid, bus.o_ifmap}, {1'b1, 1'b0, 4'h0, 32'h0});
        check_value($sformatf("%s.nreads", tag), rd_log.size(), GRP);
        for (int g = 0; g < GRP; g++)
            check_value($sformatf("%s.addr%0d", tag, g),
                        (g < rd_log.size()) ? 64'(rd_log[g]) : 64'hDEAD, 64'(8'(base + 8'(g))));
    endtask

    initial begin
        logic [7:0] rb;
        bus.i_en = 1'b0;  bus.i_base_addr = '0;  bus.i_pe_mask = '0;  bus.i_ready = 1'b0;
        bus3.i_en = 1'b0; bus3.i_base_addr = '0; bus3.i_pe_mask = '0; bus3.i_ready = 1'b0;
        for (int i = 0; i < 256; i++) spad_mem[i] = 16'($urandom);

        #1 i_nrst = 1'b0;
        #1;
        check_value("reset.outs", {bus.o_spad_rd_en, bus.o_spad_addr, bus.o_ifmap, bus.o_valid, bus.o_busy, bus.o_done}, '0);
        repeat (2) @(negedge i_clk);
        i_nrst = 1'b1;
        @(negedge i_clk);

        spad_mem[8'h10] = 16'hA1B2;
        spad_mem[8'h11] = 16'hC3D4;
        run_xfer(8'h10, 4'hF, 0, "t1");
        run_xfer(8'h10, 4'b1010, 0, "t3");
        run_xfer(8'h10, 4'hF, 5, "t4");
        spad_mem[8'hFF] = 16'h5A6B;
        spad_mem[8'h00] = 16'h7C8D;
        run_xfer(8'hFF, 4'hF, 1, "t5");
        repeat (2) @(negedge i_clk);

        // Reset in the middle of READ
        rd_log.delete();
        bus.i_en = 1'b1; bus.i_base_addr = 8'h20; bus.i_pe_mask = 4'hF; bus.i_ready = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        bus.i_en = 1'b0;
        @(posedge i_clk); #2;
        i_nrst = 1'b0;
        #1;
        check_value("t6.rst_outs", {bus.o_spad_rd_en, bus.o_spad_addr, bus.o_ifmap, bus.o_valid, bus.o_busy, bus.o_done}, '0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        rd_log.delete();
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); @(negedge i_clk);
            check_value($sformatf("t6.quiet%0d", i), {bus.o_valid, bus.o_done, bus.o_busy, bus.o_spad_rd_en}, '0);
        end
        check_value("t6.noreads", rd_log.size(), 0);
        bus.i_ready = 1'b0;
        run_xfer(8'h10, 4'hF, 0, "t6.after");

        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            spad_mem[rb]              = 16'($urandom);
            spad_mem[8'(rb + 8'd1)]   = 16'($urandom);
            run_xfer(rb, 4'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end

        // Three-PE instance: tail lane of the last word is dropped
        spad_mem[8'h00] = 16'h1122;
        spad_mem[8'h01] = 16'h33FF;
        rd_log3.delete();
        bus3.i_en = 1'b1; bus3.i_base_addr = 8'h00; bus3.i_pe_mask = 3'b111; bus3.i_ready = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        bus3.i_en = 1'b0;
        repeat (3) begin @(posedge i_clk); @(negedge i_clk); end
        check_value("t2.valid", bus3.o_valid, 3'b111);
        check_value("t2.ifmap", bus3.o_ifmap, 24'h112233);
        @(posedge i_clk); @(negedge i_clk);
        bus3.i_ready = 1'b0;
        check_value("t2.done", {bus3.o_done, bus3.o_valid}, {1'b1, 3'b000});
        check_value("t2.nreads", rd_log3.size(), 2);
        check_value("t2.reads", (rd_log3.size() == 2) ? {rd_log3[0], rd_log3[1]} : 16'hDEAD, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
